// File: rtl/gstmcu_pkg.sv
// Shared slot-arbitration constants, slot owner encoding and the priority
// helper used by the video/refresh/CPU bus slot arbiter.
package gstmcu_pkg;

  localparam logic [1:0] SLOT_PHASE         = 2'd3;  // phase in which grants are visible
  localparam logic [1:0] DECIDE_PHASE       = 2'd2;  // phase in which the winner is registered
  localparam logic [2:0] OCC_DEPTH          = 3'd4;  // video word buffer depth
  localparam int         REF_PERIOD_DEFAULT = 64;    // slots between refresh requests
  localparam int         VADDR_W            = 22;    // video word address width

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_REF  = 2'd2,
    OWN_CPU  = 2'd3
  } slot_owner_t;

  // Fixed priority: video first, then refresh, then CPU.
  function automatic slot_owner_t pick_owner(input logic vid_req,
                                             input logic ref_req,
                                             input logic cpu_req);
    slot_owner_t owner;
    if (vid_req) begin
      owner = OWN_VID;
    end else if (ref_req) begin
      owner = OWN_REF;
    end else if (cpu_req) begin
      owner = OWN_CPU;
    end else begin
      owner = OWN_NONE;
    end
    return owner;
  endfunction

endpackage

// File: rtl/vid_slot_arb_ref_timer.sv
// Refresh timer: counts bus slots and raises a refresh request once every
// REF_PERIOD slots. The request is visible during the wrapping slot itself and
// stays pending until a refresh grant; a second wrap while pending does not
// queue an extra refresh.
module ref_timer
  import gstmcu_pkg::*;
#(
  parameter int REF_PERIOD = REF_PERIOD_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic slot,
  input  logic grant,
  output logic ref_req
);

  localparam logic [7:0] WRAP_AT = 8'(REF_PERIOD - 1);

  logic [7:0] count_r;
  logic       pend_r;
  logic       wrap_s;

  assign wrap_s  = (count_r == WRAP_AT);
  assign ref_req = pend_r | wrap_s;

  // Slot counter and pending flag, advanced once per slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 8'd0;
      pend_r  <= 1'b0;
    end else if (slot) begin
      count_r <= wrap_s ? 8'd0 : (count_r + 8'd1);
      pend_r  <= (pend_r | wrap_s) & ~grant;
    end else begin
      count_r <= count_r;
      pend_r  <= pend_r;
    end
  end

endmodule

// File: rtl/vid_slot_arb.sv
// Video/refresh/CPU bus slot arbiter. A slot occurs every fourth m2clock
// cycle; the winner is chosen one cycle ahead and registered so that the grant
// pulse is a clean flop output during the slot cycle. Also tracks the video
// fetch address and the number of words buffered for the shifter.
module vid_slot_arb
  import gstmcu_pkg::*;
#(
  parameter int REF_PERIOD = REF_PERIOD_DEFAULT
) (
  input  logic               m2clock,
  input  logic               por,
  input  logic               de,
  input  logic               mde1,
  input  logic               vbl_load,
  input  logic [VADDR_W-1:0] vbase,
  input  logic [7:0]         line_off,
  input  logic               shifter_ld,
  input  logic               cpu_req,
  output logic               vid_grant,
  output logic               ref_grant,
  output logic               cpu_grant,
  output logic [VADDR_W-1:0] vid_addr,
  output logic [2:0]         occ,
  output logic               underrun
);

  logic [1:0]         phase_r;
  logic               slot_odd_r;
  logic               de_d_r;
  logic [2:0]         occ_r;
  logic [VADDR_W-1:0] vid_addr_r;
  logic               underrun_r;
  logic               vid_grant_r;
  logic               ref_grant_r;
  logic               cpu_grant_r;

  logic               slot_s;
  logic               decide_s;
  logic               vid_req_s;
  logic               ref_req_s;
  logic               line_end_s;
  slot_owner_t        owner_s;

  logic               vid_gnt_nxt_s;
  logic               ref_gnt_nxt_s;
  logic               cpu_gnt_nxt_s;
  logic [2:0]         occ_nxt_s;
  logic               underrun_nxt_s;
  logic [VADDR_W-1:0] addr_nxt_s;

  assign slot_s     = (phase_r == SLOT_PHASE);
  assign decide_s   = (phase_r == DECIDE_PHASE);
  // In colour modes video may only use every other slot; mono fetches every slot.
  assign vid_req_s  = de & (mde1 | ~slot_odd_r) & (occ_r < OCC_DEPTH);
  assign line_end_s = de_d_r & ~de;
  assign owner_s    = pick_owner(vid_req_s, ref_req_s, cpu_req);

  ref_timer #(
    .REF_PERIOD (REF_PERIOD)
  ) u_ref_timer (
    .clk     (m2clock),
    .rst     (por),
    .slot    (slot_s),
    .grant   (ref_grant_r),
    .ref_req (ref_req_s)
  );

  // Slot phase counter and odd/even slot tracking.
  always_ff @(posedge m2clock or posedge por) begin
    if (por) begin
      phase_r    <= 2'd0;
      slot_odd_r <= 1'b0;
      de_d_r     <= 1'b0;
    end else begin
      phase_r    <= phase_r + 2'd1;
      slot_odd_r <= slot_s ? ~slot_odd_r : slot_odd_r;
      de_d_r     <= de;
    end
  end

  // Choose the slot winner in the cycle before the slot.
  always_comb begin
    vid_gnt_nxt_s = 1'b0;
    ref_gnt_nxt_s = 1'b0;
    cpu_gnt_nxt_s = 1'b0;
    if (decide_s) begin
      case (owner_s)
        OWN_VID: vid_gnt_nxt_s = 1'b1;
        OWN_REF: ref_gnt_nxt_s = 1'b1;
        OWN_CPU: cpu_gnt_nxt_s = 1'b1;
        default: begin
          vid_gnt_nxt_s = 1'b0;
          ref_gnt_nxt_s = 1'b0;
          cpu_gnt_nxt_s = 1'b0;
        end
      endcase
    end else begin
      vid_gnt_nxt_s = 1'b0;
      ref_gnt_nxt_s = 1'b0;
      cpu_gnt_nxt_s = 1'b0;
    end
  end

  // Grant pulses, high only during the slot cycle.
  always_ff @(posedge m2clock or posedge por) begin
    if (por) begin
      vid_grant_r <= 1'b0;
      ref_grant_r <= 1'b0;
      cpu_grant_r <= 1'b0;
    end else begin
      vid_grant_r <= vid_gnt_nxt_s;
      ref_grant_r <= ref_gnt_nxt_s;
      cpu_grant_r <= cpu_gnt_nxt_s;
    end
  end

  // Next buffer occupancy, underrun flag and fetch address.
  always_comb begin
    occ_nxt_s      = occ_r;
    underrun_nxt_s = underrun_r;
    addr_nxt_s     = vid_addr_r;

    // End of a display line discards whatever is still buffered.
    if (line_end_s) begin
      occ_nxt_s = 3'd0;
    end else begin
      case ({vid_grant_r, shifter_ld})
        2'b10:   occ_nxt_s = occ_r + 3'd1;
        2'b01:   occ_nxt_s = (occ_r != 3'd0) ? (occ_r - 3'd1) : 3'd0;
        default: occ_nxt_s = occ_r;
      endcase
    end

    if (vbl_load) begin
      underrun_nxt_s = 1'b0;
    end else if (shifter_ld && !vid_grant_r && (occ_r == 3'd0)) begin
      underrun_nxt_s = 1'b1;
    end else begin
      underrun_nxt_s = underrun_r;
    end

    // Frame reload wins over per-fetch increment and the line offset.
    if (vbl_load) begin
      addr_nxt_s = vbase;
    end else if (line_end_s) begin
      addr_nxt_s = vid_addr_r + {21'd0, vid_grant_r} + {14'd0, line_off};
    end else begin
      addr_nxt_s = vid_addr_r + {21'd0, vid_grant_r};
    end
  end

  // Registered occupancy, underrun flag and fetch address.
  always_ff @(posedge m2clock or posedge por) begin
    if (por) begin
      occ_r      <= 3'd0;
      underrun_r <= 1'b0;
      vid_addr_r <= 22'd0;
    end else begin
      occ_r      <= occ_nxt_s;
      underrun_r <= underrun_nxt_s;
      vid_addr_r <= addr_nxt_s;
    end
  end

  assign vid_grant = vid_grant_r;
  assign ref_grant = ref_grant_r;
  assign cpu_grant = cpu_grant_r;
  assign vid_addr  = vid_addr_r;
  assign occ       = occ_r;
  assign underrun  = underrun_r;

endmodule

// File: tb/tb_vid_slot_arb.sv
// Directed bench for vid_slot_arb: a per-slot vector table plus hand-written
// sequences for refresh cadence, line end, underrun and mid-slot reset.
module tb_vid_slot_arb;

  logic        m2clock = 1'b0;
  logic        por = 1'b1;
  logic        de = 1'b0;
  logic        mde1 = 1'b0;
  logic        vbl_load = 1'b0;
  logic [21:0] vbase = 22'd0;
  logic [7:0]  line_off = 8'd0;
  logic        shifter_ld = 1'b0;
  logic        cpu_req = 1'b0;
  logic        vid_grant;
  logic        ref_grant;
  logic        cpu_grant;
  logic [21:0] vid_addr;
  logic [2:0]  occ;
  logic        underrun;

  int nchecks = 0;
  int nerrors = 0;

  // One record per bus slot period (four cycles starting at phase 0).
  typedef struct {
    logic        fresh;  // reset before this slot
    logic        vbl;    // vbl_load pulse in the phase-0 cycle
    logic [21:0] vb;     // vbase value
    logic        de;
    logic        mde1;
    logic        sld;    // shifter_ld pulse in the phase-0 cycle
    logic        cpu;
    logic [2:0]  gnt;    // expected {vid, ref, cpu} in the slot cycle
    logic [2:0]  occ;    // expected occ after the slot
    logic [21:0] addr;   // expected vid_addr after the slot
    logic        und;    // expected underrun after the slot
  } vec_t;

  vec_t tbl[16];

  vid_slot_arb dut (
    .m2clock    (m2clock),
    .por        (por),
    .de         (de),
    .mde1       (mde1),
    .vbl_load   (vbl_load),
    .vbase      (vbase),
    .line_off   (line_off),
    .shifter_ld (shifter_ld),
    .cpu_req    (cpu_req),
    .vid_grant  (vid_grant),
    .ref_grant  (ref_grant),
    .cpu_grant  (cpu_grant),
    .vid_addr   (vid_addr),
    .occ        (occ),
    .underrun   (underrun)
  );

  always #5 m2clock = ~m2clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", nerrors, nchecks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge m2clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_grants(input string name, input logic [2:0] exp);
    chk(name, 32'({vid_grant, ref_grant, cpu_grant}), 32'(exp));
  endtask

  // Reset, check everything is zero while held, release between edges.
  task automatic do_reset();
    por = 1'b1;
    de = 1'b0; mde1 = 1'b0; vbl_load = 1'b0; shifter_ld = 1'b0;
    cpu_req = 1'b0; line_off = 8'd0;
    tick();
    tick();
    chk_grants("reset_grants", 3'b000);
    chk("reset_occ", 32'(occ), 32'd0);
    chk("reset_addr", 32'(vid_addr), 32'd0);
    chk("reset_underrun", 32'(underrun), 32'd0);
    por = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = tbl[i];
    if (v.fresh) do_reset();
    vbase = v.vb; vbl_load = v.vbl; de = v.de; mde1 = v.mde1;
    cpu_req = v.cpu; shifter_ld = v.sld;
    tick();
    vbl_load = 1'b0; shifter_ld = 1'b0;
    tick();
    tick();
    chk_grants($sformatf("vec%0d_grants", i), v.gnt);
    tick();
    chk($sformatf("vec%0d_occ", i), 32'(occ), 32'(v.occ));
    chk($sformatf("vec%0d_addr", i), 32'(vid_addr), 32'(v.addr));
    chk($sformatf("vec%0d_underrun", i), 32'(underrun), 32'(v.und));
  endtask

  // De falls with a line offset: buffer flushed, address advanced.
  task automatic line_end_seq();
    line_off = 8'h10;
    de = 1'b0;
    tick();
    chk("line_end_occ", 32'(occ), 32'd0);
    chk("line_end_addr", 32'(vid_addr), 32'h10);
  endtask

  // Reset hits during a granted slot with occ=3, then sequencing restarts.
  task automatic por_seq();
    tick();
    tick();
    tick();
    chk_grants("por_pre_grant", 3'b100);
    por = 1'b1;
    #1;
    chk_grants("por_grants_zero", 3'b000);
    chk("por_occ_zero", 32'(occ), 32'd0);
    chk("por_addr_zero", 32'(vid_addr), 32'd0);
    chk("por_underrun_zero", 32'(underrun), 32'd0);
    #1;
    por = 1'b0;
    tick();
    chk_grants("por_resume_ph1", 3'b000);
    tick();
    chk_grants("por_resume_ph2", 3'b000);
    tick();
    chk_grants("por_resume_slot0", 3'b100);
  endtask

  initial begin
    logic [2:0] exp_g;
    int k;

    //           fresh vbl  vbase        de    mde1  sld   cpu   gnt     occ   addr         und
    // mono fetch with no consumption: four video slots, then CPU
    tbl[0]  = '{1'b1, 1'b1, 22'h000100, 1'b1, 1'b1, 1'b0, 1'b1, 3'b100, 3'd1, 22'h000101, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 22'h000100, 1'b1, 1'b1, 1'b0, 1'b1, 3'b100, 3'd2, 22'h000102, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 22'h000100, 1'b1, 1'b1, 1'b0, 1'b1, 3'b100, 3'd3, 22'h000103, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 22'h000100, 1'b1, 1'b1, 1'b0, 1'b1, 3'b100, 3'd4, 22'h000104, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 22'h000100, 1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 3'd4, 22'h000104, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 22'h000100, 1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 3'd4, 22'h000104, 1'b0};
    // colour pace: video on even slots, shifter drains after each fetch, CPU on odd slots
    tbl[6]  = '{1'b1, 1'b0, 22'h000000, 1'b1, 1'b0, 1'b0, 1'b1, 3'b100, 3'd1, 22'h000001, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 22'h000000, 1'b1, 1'b0, 1'b1, 1'b1, 3'b001, 3'd0, 22'h000001, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 22'h000000, 1'b1, 1'b0, 1'b0, 1'b1, 3'b100, 3'd1, 22'h000002, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 22'h000000, 1'b1, 1'b0, 1'b1, 1'b1, 3'b001, 3'd0, 22'h000002, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 22'h000000, 1'b1, 1'b0, 1'b0, 1'b1, 3'b100, 3'd1, 22'h000003, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 22'h000000, 1'b1, 1'b0, 1'b1, 1'b1, 3'b001, 3'd0, 22'h000003, 1'b0};
    // address wrap from the top of the 22-bit space
    tbl[12] = '{1'b1, 1'b1, 22'h3FFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 3'd1, 22'h000000, 1'b0};
    // fill to occ=3 ahead of the mid-slot reset
    tbl[13] = '{1'b1, 1'b0, 22'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 3'd1, 22'h000001, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 22'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 3'd2, 22'h000002, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 22'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 3'd3, 22'h000003, 1'b0};

    // Refresh cadence: CPU owns every slot except slots 63 and 127.
    do_reset();
    de = 1'b0;
    cpu_req = 1'b1;
    for (int n = 1; n <= 520; n++) begin
      tick();
      exp_g = 3'b000;
      if ((n % 4) == 3) begin
        k = n / 4;
        exp_g = ((k % 64) == 63) ? 3'b010 : 3'b001;
      end
      chk_grants($sformatf("refcpu_cycle%0d", n), exp_g);
    end

    // Table-driven slot vectors with the multi-cycle sequences attached.
    for (int i = 0; i < 16; i++) begin
      run_vec(i);
      if (i == 12) line_end_seq();
      if (i == 15) por_seq();
    end

    // Underrun is sticky until a frame reload.
    do_reset();
    shifter_ld = 1'b1;
    tick();
    shifter_ld = 1'b0;
    chk("underrun_set", 32'(underrun), 32'd1);
    chk("underrun_occ", 32'(occ), 32'd0);
    tick();
    tick();
    tick();
    chk("underrun_sticky", 32'(underrun), 32'd1);
    vbase = 22'h2AAAAA;
    vbl_load = 1'b1;
    tick();
    vbl_load = 1'b0;
    chk("underrun_cleared", 32'(underrun), 32'd0);
    chk("vbl_addr", 32'(vid_addr), 32'h2AAAAA);

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule

// File: doc/vid_slot_arb.md
VID_SLOT_ARB -- requirements
Module: vid_slot_arb

Interface
REQ-001 SHALL have port m2clock  input  1  master clock; all state updates on rising edge.
REQ-002 SHALL have port por  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port de  input  1  display enable from horizontal/vertical DE generation.
REQ-004 SHALL have port mde1  input  1  mono mode; video fetch pace select.
REQ-005 SHALL have port vbl_load  input  1  one-cycle pulse; loads video address from vbase.
REQ-006 SHALL have port vbase  input  22  video base word address.
REQ-007 SHALL have port line_off  input  8  word offset added at end of each display line.
REQ-008 SHALL have port shifter_ld  input  1  shifter consumed one buffered word.
REQ-009 SHALL have port cpu_req  input  1  CPU bus request, level, held until cpu_grant.
REQ-010 SHALL have port vid_grant, ref_grant, cpu_grant  output  1 each  one-cycle slot grant pulses.
REQ-011 SHALL have port vid_addr  output  22  current video fetch word address.
REQ-012 SHALL have port occ  output  3  buffered video words, 0..4.
REQ-013 SHALL have port underrun  output  1  sticky shifter-underrun flag.
REQ-014 SHALL have parameter REF_PERIOD, default 64, slots between refresh requests.

Function
REQ-015 SHALL run 2-bit phase counter; a bus slot occurs when phase==3, i.e. every 4 m2clock cycles.
REQ-016 SHALL toggle slot_odd at each slot; when mde1=0 video is eligible only on slots with slot_odd=0; when mde1=1 on every slot.
REQ-017 SHALL treat video as requesting when de=1, eligible, and occ<4.
REQ-018 SHALL grant at each slot by fixed priority video > refresh > CPU, at most one grant per slot, grants asserted only in the phase==3 cycle.
REQ-019 SHALL count slots in an 8-bit refresh counter; at REF_PERIOD-1 wrap it sets ref_pend; ref_grant clears ref_pend; wrap while pending leaves one pending (no queueing).
REQ-020 SHALL assert cpu_grant only when cpu_req=1 and no video or refresh grant that slot.
REQ-021 SHALL increment vid_addr by 1 on each vid_grant, modulo 2^22.
REQ-022 SHALL update occ: +1 on vid_grant, -1 on shifter_ld, unchanged when both; saturates at 4 by construction of REQ-017.
REQ-023 SHALL on shifter_ld with occ=0 leave occ at 0 and set underrun; underrun clears only on reset or vbl_load.
REQ-024 SHALL detect de falling edge (registered de_d=1, de=0); next cycle occ clears to 0 and vid_addr += line_off.
REQ-025 SHALL on vbl_load load vid_addr=vbase, overriding same-cycle increment and line_off addition.
REQ-026 SHALL keep vid_addr, occ combinational-free (registered outputs); grants may be decoded from registered state plus cpu_req.

Reset
REQ-027 SHALL on por=1 asynchronously force phase=0, slot_odd=0, refresh count=0, ref_pend=0, occ=0, vid_addr=0, underrun=0, de_d=0, all grants 0.
REQ-028 SHALL resume slot sequencing from phase 0 on first edge after por deasserts; reset mid-slot drops that slot's grant.

Structure
REQ-029 SHALL place slot phase constant (SLOT_PHASE=3), occ depth (4) and REF_PERIOD default in shared gstmcu package.
REQ-030 SHALL be one module; refresh timer as natural sub-module ref_timer.

Verification
REQ-031 SHALL test: de=0, cpu_req=1 constant -> cpu_grant every 4 cycles, except ref_grant at slot 63, 127.
REQ-032 SHALL test: mde1=1, de=1, shifter_ld never -> 4 vid_grants on consecutive slots, occ=4, then CPU gets slots; vid_addr=vbase+4.
REQ-033 SHALL test: mde1=0, de=1, shifter_ld after each grant -> vid_grant every 8 cycles, CPU on alternate slots.
REQ-034 SHALL test: vbase=0x3FFFFF, vbl_load, one vid_grant -> vid_addr=0; de fall with line_off=0x10 -> vid_addr=0x10, occ=0.
REQ-035 SHALL test: shifter_ld at occ=0 -> underrun=1, occ=0; vbl_load -> underrun=0.
REQ-036 SHALL test: por asserted mid-operation with occ=3 -> all outputs zero immediately, no grant in that slot.
